// File: rtl/ram_rd_stream_pkg.sv
// ram_rd_stream_pkg: shared sizing helpers for the RAM read stream controller
package ram_rd_stream_pkg;

    localparam int FIFO_SLACK = 2;

    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_rd_rsp_fifo.sv
// ram_rd_rsp_fifo: synchronous response FIFO whose head is held in a register
module ram_rd_rsp_fifo
    import ram_rd_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = credit_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] head_nxt;
    logic             do_pop;

    assign empty  = cnt == '0;
    assign do_pop = pop & ~empty;
    assign wr_nxt = wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
    assign rd_nxt = rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;

    // Next head: the following entry on a pop, or the incoming word when it becomes the oldest
    always_comb begin
        head_nxt = (do_pop && cnt > CW'(1)) ? mem[rd_nxt] :
                   (push && cnt == CW'(do_pop)) ? din : head;
    end

    // Ring storage; every push is written so the head can later be refilled from it
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and the registered head
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            if (push) wr_ptr <= wr_nxt;
            if (do_pop) rd_ptr <= rd_nxt;
            cnt  <= cnt + CW'(push) - CW'(do_pop);
            head <= head_nxt;
        end
    end

endmodule

// File: rtl/ram_rd_stream_ctrl.sv
// ram_rd_stream_ctrl: valid/ready read client for one RAM read port with credit-based response buffering
module ram_rd_stream_ctrl
    import ram_rd_stream_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 512,
    parameter int RAM_LATENCY    = 0,
    parameter int OUT_FIFO_DEPTH = RAM_LATENCY + FIFO_SLACK
) (
    input  logic                     clk,
    input  logic                     s_rst_n,
    input  logic                     req_vld,
    output logic                     req_rdy,
    input  logic [$clog2(DEPTH)-1:0] req_add,
    output logic                     rsp_vld,
    input  logic                     rsp_rdy,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     ram_rd_en,
    output logic [$clog2(DEPTH)-1:0] ram_rd_add,
    input  logic [WIDTH-1:0]         ram_rd_data,
    output logic                     busy
);

    localparam int CW = credit_w(OUT_FIFO_DEPTH);

    logic [CW-1:0] credit_cnt;
    logic          accept, pop, push, empty;

    if (OUT_FIFO_DEPTH < 1 || RAM_LATENCY < 0) begin : g_bad_cfg
        $fatal(1, "ram_rd_stream_ctrl: OUT_FIFO_DEPTH must be >= 1 and RAM_LATENCY >= 0");
    end

    assign req_rdy    = s_rst_n & (credit_cnt < CW'(OUT_FIFO_DEPTH));
    assign accept     = req_vld & req_rdy;
    assign ram_rd_en  = accept;
    assign ram_rd_add = req_add;
    assign rsp_vld    = ~empty;
    assign pop        = rsp_vld & rsp_rdy;
    assign busy       = credit_cnt != '0;

    // Credits reserve a FIFO slot at accept time so a RAM return can never overflow
    always_ff @(posedge clk) begin
        if (!s_rst_n) credit_cnt <= '0;
        else          credit_cnt <= credit_cnt + CW'(accept) - CW'(pop);
    end

    if (RAM_LATENCY == 0) begin : g_lat0
        assign push = accept;
    end else begin : g_pipe
        logic [RAM_LATENCY-1:0] pipe;
        // Delay accept flags so each push lines up with the RAM returning that read
        always_ff @(posedge clk) begin
            if (!s_rst_n) pipe <= '0;
            else          pipe <= (pipe << 1) | RAM_LATENCY'(accept);
        end
        assign push = pipe[RAM_LATENCY-1];
    end

    ram_rd_rsp_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(OUT_FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .s_rst_n(s_rst_n),
        .push   (push),
        .pop    (pop),
        .din    (ram_rd_data),
        .empty  (empty),
        .head   (rsp_data)
    );

endmodule

// File: tb/tb_ram_rd_stream_ctrl.sv
// tb_ram_rd_stream_ctrl: scoreboard bench for the RAM read stream controller
module tb_ram_rd_stream_ctrl;

    localparam int AW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, vld_a, rdy_a, rv_a, rr_a, en_a, busy_a;
    logic [AW-1:0] add_a, radd_a;
    logic [7:0]    rdata_a, rd_a;
    logic          rst_b, vld_b, rdy_b, rv_b, rr_b, en_b, busy_b;
    logic [AW-1:0] add_b, radd_b;
    logic [7:0]    rdata_b, rd_b;

    logic [7:0] ram [512];
    logic [7:0] d1, d2, exp_a, exp_b;
    logic [7:0] q_a[$], q_b[$];
    int chk = 0, pass = 0, cyc = 0;

    ram_rd_stream_ctrl #(.WIDTH(8), .DEPTH(512), .RAM_LATENCY(2), .OUT_FIFO_DEPTH(4)) dut_a (
        .clk(clk), .s_rst_n(rst_a), .req_vld(vld_a), .req_rdy(rdy_a), .req_add(add_a),
        .rsp_vld(rv_a), .rsp_rdy(rr_a), .rsp_data(rdata_a), .ram_rd_en(en_a),
        .ram_rd_add(radd_a), .ram_rd_data(rd_a), .busy(busy_a));

    ram_rd_stream_ctrl #(.WIDTH(8), .DEPTH(512), .RAM_LATENCY(0), .OUT_FIFO_DEPTH(4)) dut_b (
        .clk(clk), .s_rst_n(rst_b), .req_vld(vld_b), .req_rdy(rdy_b), .req_add(add_b),
        .rsp_vld(rv_b), .rsp_rdy(rr_b), .rsp_data(rdata_b), .ram_rd_en(en_b),
        .ram_rd_add(radd_b), .ram_rd_data(rd_b), .busy(busy_b));

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (en_a) d1 <= ram[radd_a];
        d2 <= d1;
    end
    assign rd_a = d2;
    assign rd_b = ram[radd_b];

    always @(negedge clk) begin
        if (!rst_a) q_a.delete();
        else begin
            if (rv_a && rr_a) begin
                chk++;
                if (q_a.size() == 0) $display("FAIL sb_a_unexpected rsp_data=%h expected no response", rdata_a);
                else begin
                    exp_a = q_a.pop_front();
                    if (rdata_a !== exp_a) $display("FAIL sb_a_data got %h expected %h", rdata_a, exp_a);
                    else pass++;
                end
            end
            if (vld_a && rdy_a) q_a.push_back(ram[add_a]);
        end
    end

    always @(negedge clk) begin
        if (!rst_b) q_b.delete();
        else begin
            if (rv_b && rr_b) begin
                chk++;
                if (q_b.size() == 0) $display("FAIL sb_b_unexpected rsp_data=%h expected no response", rdata_b);
                else begin
                    exp_b = q_b.pop_front();
                    if (rdata_b !== exp_b) $display("FAIL sb_b_data got %h expected %h", rdata_b, exp_b);
                    else pass++;
                end
            end
            if (vld_b && rdy_b) q_b.push_back(ram[add_b]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a(output bit ok);
        ok = 0;
        rr_a = 1; vld_a = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy_a && q_a.size() == 0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        rst_a = 0; rst_b = 0; vld_a = 1; add_a = 3; rr_a = 0;
        vld_b = 0; add_b = 0; rr_b = 0;
        tick; tick;
        @(negedge clk);
        chk++; if (rdy_a !== 1'b0) $display("FAIL reset_req_rdy got %b expected 0", rdy_a); else pass++;
        chk++; if (en_a !== 1'b0) $display("FAIL reset_ram_rd_en got %b expected 0", en_a); else pass++;
        chk++; if (rv_a !== 1'b0) $display("FAIL reset_rsp_vld got %b expected 0", rv_a); else pass++;
        chk++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy_a); else pass++;
        chk++; if (rdata_a !== 8'h00) $display("FAIL reset_rsp_data got %h expected 00", rdata_a); else pass++;
        tick;
        rst_a = 1; rst_b = 1; vld_a = 0;
        @(negedge clk);
        chk++; if (rdy_a !== 1'b1) $display("FAIL release_req_rdy got %b expected 1", rdy_a); else pass++;
        chk++; if (rv_a !== 1'b0) $display("FAIL release_rsp_vld got %b expected 0", rv_a); else pass++;
    endtask

    task automatic test_single;
        int lat;
        lat = 0;
        ram[5] = 8'hA5;
        rr_a = 1;
        tick;
        vld_a = 1; add_a = 5;
        #1;
        chk++; if (en_a !== 1'b1) $display("FAIL single_ram_rd_en got %b expected 1", en_a); else pass++;
        chk++; if (radd_a !== 9'd5) $display("FAIL single_ram_rd_add got %0d expected 5", radd_a); else pass++;
        for (int k = 1; k <= 8; k++) begin
            tick;
            vld_a = 0;
            @(negedge clk);
            if (rv_a) begin lat = k; break; end
        end
        chk++; if (lat != 3) $display("FAIL single_latency got %0d expected 3", lat); else pass++;
        chk++; if (rdata_a !== 8'hA5) $display("FAIL single_rsp_data got %h expected a5", rdata_a); else pass++;
        tick;
        @(negedge clk);
        chk++; if (busy_a !== 1'b0) $display("FAIL single_busy_after_pop got %b expected 0", busy_a); else pass++;
        chk++; if (rv_a !== 1'b0) $display("FAIL single_rsp_vld_after_pop got %b expected 0", rv_a); else pass++;
    endtask

    task automatic test_stream;
        int n, prev, drops, gaps;
        n = 0; prev = 0; drops = 0; gaps = 0;
        for (int i = 0; i < 16; i++) ram[i] = 8'(i + 16);
        rr_a = 1;
        for (int i = 0; i < 30; i++) begin
            tick;
            vld_a = i < 16;
            add_a = AW'(i);
            @(negedge clk);
            if (i < 16 && !rdy_a) drops++;
            if (rv_a) begin
                if (n > 0 && cyc != prev + 1) gaps++;
                prev = cyc;
                n++;
            end
        end
        vld_a = 0;
        chk++; if (drops != 0) $display("FAIL stream_req_rdy_drops got %0d expected 0", drops); else pass++;
        chk++; if (gaps != 0) $display("FAIL stream_rsp_gaps got %0d expected 0", gaps); else pass++;
        chk++; if (n != 16) $display("FAIL stream_rsp_count got %0d expected 16", n); else pass++;
    endtask

    task automatic test_backpressure;
        int acc, unstable;
        bit seen, ok;
        logic [7:0] held;
        acc = 0; unstable = 0; seen = 0; held = '0;
        rr_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            vld_a = 1;
            add_a = AW'(32 + acc);
            @(negedge clk);
            if (rdy_a) acc++;
            if (rv_a) begin
                if (seen && rdata_a !== held) unstable++;
                held = rdata_a;
                seen = 1;
            end
        end
        chk++; if (acc != 4) $display("FAIL bp_accepts got %0d expected 4", acc); else pass++;
        chk++; if (rdy_a !== 1'b0) $display("FAIL bp_req_rdy_full got %b expected 0", rdy_a); else pass++;
        chk++; if (busy_a !== 1'b1) $display("FAIL bp_busy got %b expected 1", busy_a); else pass++;
        chk++; if (unstable != 0) $display("FAIL bp_rsp_data_stable got %0d changes expected 0", unstable); else pass++;
        chk++; if (held !== ram[32]) $display("FAIL bp_head got %h expected %h", held, ram[32]); else pass++;
        tick;
        rr_a = 1;
        @(negedge clk);
        chk++; if (rdy_a !== 1'b0) $display("FAIL bp_rdy_pop_cycle got %b expected 0", rdy_a); else pass++;
        tick;
        @(negedge clk);
        chk++; if (rdy_a !== 1'b1) $display("FAIL bp_rdy_after_pop got %b expected 1", rdy_a); else pass++;
        tick;
        drain_a(ok);
        chk++; if (!ok) $display("FAIL bp_drain got busy=%b expected idle", busy_a); else pass++;
    endtask

    task automatic test_full_count;
        bit full, ok;
        full = 0;
        rr_a = 0; vld_a = 1; add_a = 64;
        for (int k = 0; k < 10; k++) begin
            tick;
            add_a = AW'(add_a + 1);
            @(negedge clk);
            if (!rdy_a) begin full = 1; break; end
        end
        chk++; if (!full) $display("FAIL fc_fill got req_rdy=%b expected 0", rdy_a); else pass++;
        tick; rr_a = 1; add_a = AW'(add_a + 1);
        @(negedge clk);
        chk++; if (rdy_a !== 1'b0) $display("FAIL fc_pop_only_cycle got %b expected 0", rdy_a); else pass++;
        tick; add_a = AW'(add_a + 1);
        @(negedge clk);
        chk++; if (rdy_a !== 1'b1) $display("FAIL fc_count3_rdy got %b expected 1", rdy_a); else pass++;
        tick; rr_a = 0; add_a = AW'(add_a + 1);
        @(negedge clk);
        chk++; if (rdy_a !== 1'b1) $display("FAIL fc_after_both_rdy got %b expected 1", rdy_a); else pass++;
        tick; add_a = AW'(add_a + 1);
        @(negedge clk);
        chk++; if (rdy_a !== 1'b0) $display("FAIL fc_refull_rdy got %b expected 0", rdy_a); else pass++;
        tick;
        drain_a(ok);
        chk++; if (!ok) $display("FAIL fc_drain got busy=%b expected idle", busy_a); else pass++;
    endtask

    task automatic test_lat0_reset;
        int bad;
        bad = 0;
        rr_b = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            vld_b = 1;
            add_b = AW'(i + 1);
        end
        tick;
        vld_b = 0;
        @(negedge clk);
        chk++; if (busy_b !== 1'b1) $display("FAIL l0_busy_inflight got %b expected 1", busy_b); else pass++;
        chk++; if (rv_b !== 1'b1) $display("FAIL l0_rsp_vld_inflight got %b expected 1", rv_b); else pass++;
        tick; rst_b = 0;
        tick; rst_b = 1; rr_b = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rv_b || busy_b) bad++;
        end
        chk++; if (bad != 0) $display("FAIL l0_after_reset got %0d active cycles expected 0", bad); else pass++;
        ram[9] = 8'h3C;
        tick;
        vld_b = 1; add_b = 9;
        #1;
        chk++; if (en_b !== 1'b1) $display("FAIL l0_ram_rd_en got %b expected 1", en_b); else pass++;
        tick;
        vld_b = 0;
        @(negedge clk);
        chk++; if (rv_b !== 1'b1) $display("FAIL l0_rsp_vld got %b expected 1", rv_b); else pass++;
        chk++; if (rdata_b !== 8'h3C) $display("FAIL l0_rsp_data got %h expected 3c", rdata_b); else pass++;
        tick;
        @(negedge clk);
        chk++; if (busy_b !== 1'b0) $display("FAIL l0_busy_after_pop got %b expected 0", busy_b); else pass++;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 8'(i * 7 + 3);
        test_reset;
        test_single;
        test_stream;
        test_backpressure;
        test_full_count;
        test_lat0_reset;
        tick;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
